pipe_stage_skid: RTL
====================

PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 Parameter DW, default 32: payload width in bits, legal range 1..256.
REQ-002 Parameter SKID, default 1: 0 = single-entry stage; 1 = two-entry stage with a registered in_allow.
REQ-003 Parameter CLR_DATA, default 1: 1 = clear and reset zero the payload registers; 0 = payload is held and only valid bits are cleared.
REQ-004 Parameter SCW, default 16: stall-counter width, minimum 2.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 rst_n  in  1  reset, asynchronous assertion, active-low.
REQ-007 clear  in  1  synchronous flush of every entry in the stage.
REQ-008 validin  in  1  upstream has a payload this cycle.
REQ-009 in_data  in  DW  upstream payload.
REQ-010 in_allow  out  1  stage can accept a payload this cycle.
REQ-011 pipe_ready_go  in  1  the output entry's processing is complete.
REQ-012 out_allow  in  1  downstream can accept a payload.
REQ-013 validout  out  1  output entry is valid and ready to transfer.
REQ-014 out_data  out  DW  output entry payload.
REQ-015 occupancy  out  2  number of valid entries (0..2).
REQ-016 stall_cnt  out  SCW  saturating count of back-pressure cycles.

Function
REQ-017 Accept event: validin && in_allow. Depart event: validout && out_allow.
REQ-018 validout SHALL equal main_valid && pipe_ready_go in both modes.
REQ-019 SKID=0: in_allow = !main_valid || (pipe_ready_go && out_allow) (combinational). main_valid and out_data SHALL load on every cycle where in_allow is high, so main_valid follows validin and out_data loads on an accept.
REQ-020 SKID=1: in_allow = !skid_valid. This is a pure register output with no combinational path from out_allow or pipe_ready_go.
REQ-021 SKID=1 accept, main empty or departing this cycle, skid empty: the payload goes to main next cycle.
REQ-022 SKID=1 accept, main valid and not departing: the payload goes to skid next cycle and skid_valid is set.
REQ-023 SKID=1 depart with skid_valid set: the skid payload moves to main next cycle, skid_valid is cleared, and main_valid stays 1.
REQ-024 SKID=1 depart with skid empty and no accept: main_valid is cleared next cycle.
REQ-025 Ordering SHALL be strict FIFO; no payload is dropped or duplicated.
REQ-026 Latency from accept to the earliest validout is exactly 1 cycle when main is empty.
REQ-027 occupancy = main_valid + skid_valid. It is always 0..1 when SKID=0.
REQ-028 stall_cnt increments by 1 in each cycle where main_valid && pipe_ready_go && !out_allow. It saturates at 2^SCW-1 and does not wrap.
REQ-029 clear SHALL have priority over accept and depart in the same cycle. Next cycle: main_valid=0, skid_valid=0, in_allow=1, and the payload registers are zeroed if CLR_DATA=1. stall_cnt is unaffected.
REQ-030 A depart is still seen downstream in a clear cycle (validout is combinational that cycle). Upstream treats a simultaneous accept as discarded.
REQ-031 pipe_ready_go=0 SHALL hold main indefinitely. In SKID=1 mode the stage still absorbs one payload into skid.

Reset
REQ-032 When rst_n=0, immediately and regardless of clk: main_valid=0, skid_valid=0, validout=0, occupancy=0, stall_cnt=0, and out_data=0 (the payload registers are reset in every CLR_DATA setting).
REQ-033 While rst_n=0, in_allow SHALL read 1 in both modes.
REQ-034 Reset asserted mid-transfer SHALL discard all entries. Behaviour resumes with no spurious validout on the first clock after deassertion.

Verification
REQ-035 SKID=1, DW=8, out_allow=1, pipe_ready_go=1, in_data=0x01,0x02,0x03 on consecutive cycles -> out_data 0x01,0x02,0x03 one cycle later each, occupancy never exceeds 1, in_allow stays 1.
REQ-036 SKID=1, out_allow=0, push 0xA0 then 0xA1 -> occupancy 2, in_allow=0, third push (0xA2) not accepted. Raise out_allow -> 0xA0, then 0xA1 depart in order and in_allow returns to 1 the cycle after the first depart.
REQ-037 SKID=0, main holds 0x55, out_allow=0, validin=1 -> in_allow=0. Set out_allow=1 in the same cycle -> in_allow=1 combinationally and 0x55 departs while the new payload loads.
REQ-038 occupancy=2, clear=1 together with validin=1 -> next cycle occupancy=0, validout=0, out_data=0 (CLR_DATA=1); the same stimulus with CLR_DATA=0 leaves out_data unchanged.
REQ-039 SCW=2, hold main_valid=1, pipe_ready_go=1, out_allow=0 for 6 cycles -> stall_cnt 1,2,3,3,3,3. Then pulse rst_n low mid-cycle -> all outputs at reset values before the next clk edge.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/allow pipeline stage with optional skid entry and saturating stall counter
module pipe_stage_skid #(
  parameter int DW       = 32,
  parameter int SKID     = 1,
  parameter int CLR_DATA = 1,
  parameter int SCW      = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clear,
  input  logic           validin,
  input  logic [DW-1:0]  in_data,
  output logic           in_allow,
  input  logic           pipe_ready_go,
  input  logic           out_allow,
  output logic           validout,
  output logic [DW-1:0]  out_data,
  output logic [1:0]     occupancy,
  output logic [SCW-1:0] stall_cnt
);
  logic          main_valid, skid_valid, mv_n, sv_n, accept, depart, stall;
  logic [DW-1:0] main_data, skid_data, md_n, sd_n;
  assign validout  = main_valid && pipe_ready_go;
  assign depart    = validout && out_allow;
  // skid mode decouples in_allow from downstream: it depends only on the skid register
  assign in_allow  = (SKID != 0) ? !skid_valid : (!main_valid || (pipe_ready_go && out_allow));
  assign accept    = validin && in_allow;
  assign stall     = main_valid && pipe_ready_go && !out_allow;
  assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};
  assign out_data  = main_data;
  always_comb begin
    mv_n = main_valid;
    md_n = main_data;
    sv_n = skid_valid;
    sd_n = skid_data;
    if (clear) begin
      mv_n = 1'b0;
      sv_n = 1'b0;
      if (CLR_DATA != 0) begin
        md_n = '0;
        sd_n = '0;
      end
    end else if (SKID == 0) begin
      if (in_allow) begin
        mv_n = validin;
        if (validin) md_n = in_data;
      end
    end else if (main_valid && !depart) begin
      if (accept) begin
        sv_n = 1'b1;
        sd_n = in_data;
      end
    end else if (skid_valid) begin
      mv_n = 1'b1;
      md_n = skid_data;
      sv_n = 1'b0;
    end else begin
      mv_n = accept;
      if (accept) md_n = in_data;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_data  <= '0;
      skid_data  <= '0;
      stall_cnt  <= '0;
    end else begin
      main_valid <= mv_n;
      skid_valid <= sv_n;
      main_data  <= md_n;
      skid_data  <= sd_n;
      stall_cnt  <= (stall && stall_cnt != '1) ? stall_cnt + SCW'(1) : stall_cnt;
    end
  end
endmodule
